// File: rtl/sdram_req_arbiter_if.sv
// sdram_req_arbiter_if: requester handshake and sdram_controller strobes of sdram_req_arbiter.
interface sdram_req_arbiter_if #(parameter int NUM_REQ = 4);
   logic [NUM_REQ-1:0] req_valid, req_we, grant, req_done;
   logic busy, sdram_read_req, sdram_write_req, sdram_data_valid, timeout_err;
   modport master (
      output req_valid, req_we, sdram_data_valid,
      input  grant, req_done, busy, sdram_read_req, sdram_write_req, timeout_err
   );
   modport slave (
      input  req_valid, req_we, sdram_data_valid,
      output grant, req_done, busy, sdram_read_req, sdram_write_req, timeout_err
   );
endinterface

// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter: round-robin arbiter serialising NUM_REQ requesters onto one sdram_controller.
// Defining SDRAM_ARB_TIMEOUT_EN adds a read abort after RD_TIMEOUT cycles with a timeout_err pulse.
module sdram_req_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int WR_CYCLES  = 12,
   parameter int RD_TIMEOUT = 32
) (
   input  logic clk,
   input  logic reset,
   sdram_req_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(WR_CYCLES > RD_TIMEOUT ? WR_CYCLES : RD_TIMEOUT) + 1;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_WR, WAIT_RD, DONE} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] owner_q, owner_d, rr_q, rr_d, pick;
   logic [CW-1:0] cnt_q, cnt_d;
   logic we_q, we_d, found;
   logic [NUM_REQ-1:0] oh;
`ifdef SDRAM_ARB_TIMEOUT_EN
   logic to_q, to_d;
`endif
   function automatic logic [IW-1:0] wrap(input int v);
      return IW'(v >= NUM_REQ ? v - NUM_REQ : v);
   endfunction
   // first pending requester at or after rr_q, wrapping modulo NUM_REQ
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         if (!found && bus.req_valid[wrap(int'(rr_q) + i)]) begin
            found = 1'b1;
            pick  = wrap(int'(rr_q) + i);
         end
   end
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      we_d    = we_q;
      cnt_d   = cnt_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
      to_d    = 1'b0;
`endif
      case (state_q)
         IDLE: if (found) begin
            owner_d = pick;
            we_d    = bus.req_we[pick];
            state_d = ISSUE;
         end
         ISSUE: begin
            state_d = we_q ? WAIT_WR : WAIT_RD;
            cnt_d   = we_q ? CW'(WR_CYCLES - 1) : '0;
         end
         WAIT_WR: begin
            state_d = cnt_q == '0 ? DONE : WAIT_WR;
            cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
         end
         WAIT_RD: begin
            cnt_d = &cnt_q ? cnt_q : cnt_q + CW'(1);
            if (bus.sdram_data_valid) state_d = DONE;
`ifdef SDRAM_ARB_TIMEOUT_EN
            else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
               state_d = DONE;
               to_d    = 1'b1;
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
            rr_d    = wrap(int'(owner_q) + 1);
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q    <= '0;
         we_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
      end
   end
`ifdef SDRAM_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) to_q <= 1'b0;
      else       to_q <= to_d;
   end
   assign bus.timeout_err = state_q == DONE && to_q;
`else
   assign bus.timeout_err = 1'b0;
`endif
   // outputs decode registered state only, so reset clears them at once
   assign oh                  = NUM_REQ'(1) << owner_q;
   assign bus.busy            = state_q != IDLE;
   assign bus.grant           = state_q != IDLE ? oh : '0;
   assign bus.req_done        = state_q == DONE ? oh : '0;
   assign bus.sdram_write_req = state_q == ISSUE && we_q;
   assign bus.sdram_read_req  = state_q == ISSUE && !we_q;
endmodule
